// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt-acknowledge sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    HOLD,
    REARM
  } inta_state_t;

  localparam int unsigned INTA_LOW_DEF = 2;
  localparam int unsigned INTA_GAP_DEF = 2;
  localparam logic [2:0]  SPURIOUS_IR  = 3'b111;

endpackage

// File: rtl/pic_inta_sequencer.sv
// Processor-side 8259A INTA pulse-pair generator with vector capture and a
// valid/ready hand-off to the CPU model.
//
// state | meaning
// IDLE  | waiting for INT & intr_enable with no vector pending
// ACK1  | first INTA low pulse
// GAP   | INTA high between the two pulses
// ACK2  | second INTA low pulse, PIC drives the vector
// HOLD  | vector presented, waiting for vec_ready
// REARM | INTA high, gives the PIC time to drop INT
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES = INTA_LOW_DEF,
  parameter int unsigned INTA_GAP_CYCLES = INTA_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       intr_enable,
  input  logic [7:0] DATA_BUS,
  output logic       INTA,
  output logic       vec_valid,
  output logic [7:0] vec,
  output logic       spurious,
  input  logic       vec_ready,
  output logic       busy
);

  localparam int unsigned CNT_MAX = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                                    INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(INTA_LOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(INTA_GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  inta_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_tc;
  logic             capture;
  logic             release_vec;

  assign cnt_tc = (cnt == CNT_ONE);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    capture     = 1'b0;
    release_vec = 1'b0;
    case (state)
      IDLE: begin
        if (INT & intr_enable & ~vec_valid) begin
          state_nxt = ACK1;
          cnt_nxt   = LOW_LD;
        end
      end
      ACK1: begin
        if (cnt_tc) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_tc) begin
          state_nxt = ACK2;
          cnt_nxt   = LOW_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ACK2: begin
        if (cnt_tc) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      HOLD: begin
        if (vec_ready) begin
          state_nxt   = REARM;
          cnt_nxt     = GAP_LD;
          release_vec = 1'b1;
        end
      end
      REARM: begin
        if (cnt_tc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // INTA is registered from the next state so the pin tracks the pulse states
  // without any combinational path from INT or intr_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      INTA      <= 1'b1;
      vec_valid <= 1'b0;
      vec       <= 8'h00;
      spurious  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      INTA  <= ~((state_nxt == ACK1) | (state_nxt == ACK2));
      if (capture) begin
        vec       <= DATA_BUS;
        spurious  <= (DATA_BUS[2:0] == SPURIOUS_IR) & ~INT;
        vec_valid <= 1'b1;
      end else if (release_vec) begin
        vec_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: cycle-offset reference model,
// decoupled vector monitor, plus a short check of a (1,3) parameter variant.
module tb_pic_inta_sequencer;

  localparam int L = 2;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INT = 1'b0;
  logic       intr_enable = 1'b0;
  logic       vec_ready = 1'b0;
  logic [7:0] DATA_BUS = 8'h00;
  logic       INTA, vec_valid, spurious, busy;
  logic [7:0] vec;

  logic       int2 = 1'b0;
  logic       en2 = 1'b0;
  logic       rdy2 = 1'b1;
  logic [7:0] data2 = 8'h00;
  logic       inta2, valid2, spur2, busy2;
  logic [7:0] vec2;

  pic_inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .intr_enable(intr_enable),
    .DATA_BUS(DATA_BUS), .INTA(INTA), .vec_valid(vec_valid), .vec(vec),
    .spurious(spurious), .vec_ready(vec_ready), .busy(busy)
  );

  pic_inta_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(3)) dut_v (
    .clk(clk), .rst_n(rst_n), .INT(int2), .intr_enable(en2),
    .DATA_BUS(data2), .INTA(inta2), .vec_valid(valid2), .vec(vec2),
    .spurious(spur2), .vec_ready(rdy2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a sequence is described only by the edge it started on.
  int         cyc = 0;
  int         m_start = 0;
  int         m_ready_at = 0;
  bit         m_active = 1'b0;
  bit         m_valid = 1'b0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (m_active && m_valid && vec_ready) begin
      m_valid    = 1'b0;
      m_active   = 1'b0;
      m_ready_at = cyc + G + 1;
    end else if (m_active && cyc == m_start + 2*L + G) begin
      exp_q.push_back({DATA_BUS, (DATA_BUS[2:0] == 3'b111) && !INT});
      m_valid = 1'b1;
    end else if (!m_active && cyc >= m_ready_at && INT && intr_enable) begin
      m_active = 1'b1;
      m_start  = cyc;
    end
  endtask

  task automatic check_cycle();
    int   d = cyc - m_start;
    logic exp_inta = 1'b1;
    if (m_active && (d < L || (d >= L + G && d < 2*L + G))) exp_inta = 1'b0;
    check("inta", INTA, exp_inta);
    check("busy", busy, m_active || (cyc <= m_ready_at - 2));
    check("vec_valid", vec_valid, m_valid);
  endtask

  task automatic step(input logic i, input logic en, input logic [7:0] d, input logic r);
    INT = i;
    intr_enable = en;
    DATA_BUS = d;
    vec_ready = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    check("rst_inta", INTA, 1'b1);
    check("rst_valid", vec_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    m_active = 1'b0;
    m_valid = 1'b0;
    m_ready_at = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    @(negedge clk);
    check("reset_inta", INTA, 1'b1);
    check("reset_valid", vec_valid, 1'b0);
    check("reset_vec", vec, 8'h00);
    check("reset_spurious", spurious, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_inta_v", inta2, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    fork
      begin : monitor
        logic       prev = 1'b0;
        logic [8:0] held = '0;
        logic [8:0] e;
        forever begin
          @(negedge clk);
          if (vec_valid && !prev) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL vec_unexpected at edge %0d: got %0h expected none", cyc, vec);
            end else begin
              e = exp_q.pop_front();
              check("vec_spurious", {vec, spurious}, e);
            end
            held = {vec, spurious};
          end else if (vec_valid && prev) begin
            check("vec_hold", {vec, spurious}, held);
          end
          prev = vec_valid;
        end
      end
    join_none

    repeat (3) step(1'b0, 1'b1, 8'h00, 1'b1);

    // basic acknowledge, ready tied high
    for (int i = 0; i < 12; i++) step(i < 7, 1'b1, 8'h45, 1'b1);

    // back-pressure: ready low until edge 12, INT held high throughout
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h45, i >= 12);
    repeat (14) step(1'b0, 1'b1, 8'h00, 1'b1);

    // spurious: INT drops during the gap, PIC returns the IR7 vector
    for (int i = 0; i < 12; i++) step(i < 3, 1'b1, 8'h47, 1'b1);

    // gating by intr_enable, then release
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h21, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'h21, 1'b1);
    repeat (12) step(1'b0, 1'b1, 8'h00, 1'b1);

    // reset asserted while the second pulse is low
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h5A, 1'b1);
    reset_now();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h5A, 1'b1);
    repeat (12) step(1'b0, 1'b1, 8'h00, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rd[2:0] = 3'b111;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, rd, $urandom_range(0, 2) != 0);
    end
    repeat (20) step(1'b0, 1'b1, 8'h00, 1'b1);
    check("queue_empty", exp_q.size(), 0);

    // parameter variant L=1, G=3: trigger at offset 0
    int2 = 1'b1;
    en2 = 1'b1;
    data2 = 8'h3C;
    rdy2 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("v_inta", inta2, !(k == 0 || k == 4));
      check("v_valid", valid2, k == 5);
      check("v_busy", busy2, k <= 7);
      if (k == 5) begin
        check("v_vec", vec2, 8'h3C);
        check("v_spurious", spur2, 1'b0);
      end
      if (k == 0) int2 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
